// File: rtl/pic_8259a_pkg.sv
// Shared types and helpers for the 8259A acknowledge sequencer: ack FSM states,
// OCW2 command encodings, and the decoded OCW2 action record.
package pic_8259a_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } ack_state_t;

  // OCW2 {R, SL, EOI} command field
  localparam logic [2:0] OCW2_AEOI_ROT_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_AEOI_ROT_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef struct packed {
    logic [7:0] eoi;
    logic       rotate_load;
    logic [2:0] rotate_value;
    logic       aeoi_rotate_set;
    logic       aeoi_rotate_clear;
  } ocw2_action_t;

  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_8259a_ocw2_decoder.sv
// Combinational OCW2 decode: turns a write strobe and command byte into the
// EOI vector, rotate update and AEOI-rotate mode flags for this cycle.
module pic_8259a_ocw2_decoder
  import pic_8259a_pkg::*;
(
  input  logic         ocw2_write,
  input  logic [7:0]   ocw2_data,
  input  logic [7:0]   highest_level_in_service,
  output ocw2_action_t action
);

  logic [2:0] level;
  logic       unused_ocw2_bits;

  assign level            = ocw2_data[2:0];
  assign unused_ocw2_bits = ^ocw2_data[4:3];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    action = '0;
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        OCW2_NS_EOI: action.eoi = highest_level_in_service;
        OCW2_SP_EOI: action.eoi = 8'b1 << level;
        OCW2_ROT_NS_EOI: begin
          action.eoi          = highest_level_in_service;
          action.rotate_load  = |highest_level_in_service;
          action.rotate_value = onehot_to_index(highest_level_in_service);
        end
        OCW2_ROT_SP_EOI: begin
          action.eoi          = 8'b1 << level;
          action.rotate_load  = 1'b1;
          action.rotate_value = level;
        end
        OCW2_SET_PRIO: begin
          action.rotate_load  = 1'b1;
          action.rotate_value = level;
        end
        OCW2_AEOI_ROT_SET: action.aeoi_rotate_set   = 1'b1;
        OCW2_AEOI_ROT_CLR: action.aeoi_rotate_clear = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pic_8259a_ack_sequencer.sv
// 8259A in-service sequencer: INTA handshake FSM (8080/8086), latch and EOI
// pulses, automatic EOI, and ownership of the priority rotation pointer.
module pic_8259a_ack_sequencer
  import pic_8259a_pkg::*;
#(
  parameter logic [2:0] ROTATE_RESET   = 3'd7,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic       mode_8086,
  input  logic       auto_eoi,
  input  logic [7:0] interrupt,
  input  logic [7:0] highest_level_in_service,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic       int_out,
  output logic       latch_in_service,
  output logic [7:0] acknowledged_interrupt,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [1:0] ack_phase,
  output logic       vector_output_enable,
  output logic       spurious
);

  ack_state_t   state, state_next;
  ocw2_action_t ocw2_action;
  logic         inta_prev, inta_fall, inta_rise;
  logic         start, finish, aeoi_fire;
  logic         rotate_in_aeoi, rotate_in_aeoi_d;
  logic         int_out_d, latch_d, voe_d, spurious_d;
  logic [7:0]   ack_d, eoi_d;
  logic [2:0]   rotate_d;

  pic_8259a_ocw2_decoder u_ocw2_decoder (
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .highest_level_in_service (highest_level_in_service),
    .action                   (ocw2_action)
  );

  assign inta_fall = inta_prev & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_prev & interrupt_acknowledge_n;
  assign ack_phase = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    // INTA history keeps tracking through reset so a line held low is not an edge.
    inta_prev <= interrupt_acknowledge_n;
    if (reset) begin
      state                  <= IDLE;
      int_out                <= 1'b0;
      latch_in_service       <= 1'b0;
      acknowledged_interrupt <= '0;
      end_of_interrupt       <= '0;
      priority_rotate        <= ROTATE_RESET;
      vector_output_enable   <= 1'b0;
      spurious               <= 1'b0;
      rotate_in_aeoi         <= 1'b0;
    end else begin
      state                  <= state_next;
      int_out                <= int_out_d;
      latch_in_service       <= latch_d;
      acknowledged_interrupt <= ack_d;
      end_of_interrupt       <= eoi_d;
      priority_rotate        <= rotate_d;
      vector_output_enable   <= voe_d;
      spurious               <= spurious_d;
      rotate_in_aeoi         <= rotate_in_aeoi_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (inta_fall) state_next = ACK1;
      ACK1: if (inta_fall) state_next = ACK2;
      ACK2: begin
        if (mode_8086) begin
          if (inta_rise) state_next = IDLE;
        end else if (inta_fall) begin
          state_next = ACK3;
        end
      end
      ACK3: if (inta_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start     = (state == IDLE) && inta_fall;
    finish    = (state != IDLE) && (state_next == IDLE);
    aeoi_fire = finish && auto_eoi;

    int_out_d = (state == IDLE) && !inta_fall && (|interrupt);
    latch_d   = start && (|interrupt);
    voe_d     = ((state_next == ACK1) && !mode_8086) ||
                (state_next == ACK2) || (state_next == ACK3);

    ack_d = acknowledged_interrupt;
    if (start) ack_d = (|interrupt) ? interrupt : (8'b1 << SPURIOUS_LEVEL);

    spurious_d = spurious;
    if (start)       spurious_d = ~(|interrupt);
    else if (finish) spurious_d = 1'b0;

    eoi_d = ocw2_action.eoi;
    if (aeoi_fire && !spurious) eoi_d = eoi_d | acknowledged_interrupt;

    // An explicit OCW2 rotate outranks the automatic one in the same cycle.
    rotate_d = priority_rotate;
    if (ocw2_action.rotate_load)           rotate_d = ocw2_action.rotate_value;
    else if (aeoi_fire && rotate_in_aeoi)  rotate_d = onehot_to_index(acknowledged_interrupt);

    rotate_in_aeoi_d = rotate_in_aeoi;
    if (ocw2_action.aeoi_rotate_set)        rotate_in_aeoi_d = 1'b1;
    else if (ocw2_action.aeoi_rotate_clear) rotate_in_aeoi_d = 1'b0;
  end

endmodule
